// File: rtl/asg_pkg.sv
// asg_pkg: shared types and constants for the ASG output conditioning path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: sample_t (signed sample), slew_state_t (slew FSM states),
//           SMP_MAX / SMP_MIN (full-scale sample limits).
package asg_pkg;

  localparam int ASG_DW = 14;   // DAC sample width
  localparam int ASG_SW = 14;   // slew step width

  typedef logic signed [ASG_DW-1:0] sample_t;

  // Legacy register readback relies on this exact 2-bit encoding.
  typedef enum logic [1:0] {
    TRACK   = 2'd0,
    RAMP_DN = 2'd1,
    PARKED  = 2'd2,
    RAMP_UP = 2'd3
  } slew_state_t;

  localparam sample_t SMP_MAX = {1'b0, {(ASG_DW-1){1'b1}}};   //  8191
  localparam sample_t SMP_MIN = {1'b1, {(ASG_DW-1){1'b0}}};   // -8192

endpackage

// File: rtl/red_pitaya_asg_slew_step.sv
// red_pitaya_asg_slew_step: one slew-limit step from cur toward tgt, saturated.
// Latency: combinational.
// Backpressure: none.
// Ports: cur   - current registered output sample
//        tgt   - sample to move toward
//        step  - max |change| per cycle, 0 = jump straight to tgt
//        nxt   - next output sample
//        clamped - 1 when the step limit (not tgt) decided nxt
module red_pitaya_asg_slew_step #(
  parameter int DW = 14,
  parameter int SW = 14
) (
  input  logic signed [DW-1:0] cur,
  input  logic signed [DW-1:0] tgt,
  input  logic        [SW-1:0] step,
  output logic signed [DW-1:0] nxt,
  output logic                 clamped
);

  // Wide enough for the full tgt-cur span, any step value, and the sign
  // bit, so neither the difference nor cur +/- step can wrap.
  localparam int AW = ((SW > DW) ? SW : DW) + 2;

  localparam logic signed [AW-1:0] MAX_W = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_W = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [AW-1:0] cur_w;
  logic signed [AW-1:0] tgt_w;
  logic signed [AW-1:0] step_w;
  logic signed [AW-1:0] diff;
  logic signed [AW-1:0] mag;
  logic signed [AW-1:0] sum;

  always_comb begin
    cur_w   = {{(AW-DW){cur[DW-1]}}, cur};
    tgt_w   = {{(AW-DW){tgt[DW-1]}}, tgt};
    step_w  = {{(AW-SW){1'b0}}, step};
    diff    = tgt_w - cur_w;
    mag     = diff[AW-1] ? -diff : diff;
    sum     = cur_w;
    nxt     = tgt;
    clamped = 1'b0;
    if ((step != '0) && (mag > step_w)) begin
      clamped = 1'b1;
      sum     = diff[AW-1] ? (cur_w - step_w) : (cur_w + step_w);
      // Moving toward an in-range target cannot leave the range; the clamp
      // only guards against the output ever wrapping.
      if (sum > MAX_W)
        nxt = MAX_W[DW-1:0];
      else if (sum < MIN_W)
        nxt = MIN_W[DW-1:0];
      else
        nxt = sum[DW-1:0];
    end
  end

endmodule

// File: rtl/red_pitaya_asg_slew.sv
// red_pitaya_asg_slew: per-channel slew-rate limiter with ramp-to-zero park.
// Latency: 1 dac_clk from dat_i to dat_o when not limiting.
// Backpressure: none; a new sample is accepted every cycle.
// Ports: dac_clk_i/dac_rstn_i (sync, active low), dat_i sample in,
//        set_step_i max step (0 = bypass), set_park_i park request,
//        dat_o limited sample, slewing_o limiter active, parked_o parked,
//        hist_clr_i/hist_cnt_o slew-cycle counter.
// Build option: define ASG_SLEW_HIST_EN to implement the slew-cycle counter;
//        otherwise hist_cnt_o reads 0 and hist_clr_i is ignored.
module red_pitaya_asg_slew
  import asg_pkg::*;
#(
  parameter int DW = ASG_DW,
  parameter int SW = ASG_SW
) (
  input  logic                 dac_clk_i,
  input  logic                 dac_rstn_i,
  input  logic signed [DW-1:0] dat_i,
  input  logic        [SW-1:0] set_step_i,
  input  logic                 set_park_i,
  output logic signed [DW-1:0] dat_o,
  output logic                 slewing_o,
  output logic                 parked_o,
  input  logic                 hist_clr_i,
  output logic        [31:0]   hist_cnt_o
);

  slew_state_t          state;
  slew_state_t          state_nxt;
  logic signed [DW-1:0] trk_nxt;
  logic signed [DW-1:0] park_nxt;
  logic                 trk_clamp;
  logic                 park_clamp;
  logic signed [DW-1:0] dat_nxt;
  logic                 clamp_nxt;

  // Two candidate steps are evaluated every cycle so that a park request
  // (or its release) redirects the ramp on the very next sample, continuing
  // from the current dat_o without a reversal glitch.
  red_pitaya_asg_slew_step #(.DW(DW), .SW(SW)) u_step_trk (
    .cur     (dat_o),
    .tgt     (dat_i),
    .step    (set_step_i),
    .nxt     (trk_nxt),
    .clamped (trk_clamp)
  );

  red_pitaya_asg_slew_step #(.DW(DW), .SW(SW)) u_step_park (
    .cur     (dat_o),
    .tgt     ('0),
    .step    (set_step_i),
    .nxt     (park_nxt),
    .clamped (park_clamp)
  );

  always_comb begin
    dat_nxt   = set_park_i ? park_nxt   : trk_nxt;
    clamp_nxt = set_park_i ? park_clamp : trk_clamp;
    state_nxt = state;
    if (set_park_i) begin
      // Entering PARKED together with the first zero sample lets parked_o
      // rise on the same cycle dat_o first reads 0.
      state_nxt = (park_nxt == '0) ? PARKED : RAMP_DN;
    end else if (state != TRACK) begin
      // Leaving park: stay in RAMP_UP until the limiter stops clamping.
      state_nxt = trk_clamp ? RAMP_UP : TRACK;
    end
  end

  always_ff @(posedge dac_clk_i) begin
    if (!dac_rstn_i) begin
      state     <= TRACK;
      dat_o     <= '0;
      slewing_o <= 1'b0;
      parked_o  <= 1'b0;
    end else begin
      state     <= state_nxt;
      dat_o     <= dat_nxt;
      slewing_o <= clamp_nxt;
      parked_o  <= (state_nxt == PARKED);
    end
  end

`ifdef ASG_SLEW_HIST_EN
  // Counts cycles on which slewing_o is high; saturates, clear wins.
  always_ff @(posedge dac_clk_i) begin
    if (!dac_rstn_i || hist_clr_i)
      hist_cnt_o <= '0;
    else if (slewing_o && (hist_cnt_o != 32'hFFFF_FFFF))
      hist_cnt_o <= hist_cnt_o + 32'd1;
  end
`else
  logic unused_hist_clr;
  assign unused_hist_clr = hist_clr_i;
  assign hist_cnt_o      = '0;
`endif

endmodule
